// File: rtl/dsp_mult_resp_pkg.sv
// dsp_mult_resp_pkg: widths, request/product types and operand extension helper
// (request carries acc_clr when DSP_MULT_RESP_ACC_EN is defined)
package dsp_mult_resp_pkg;
    localparam int A_W   = 20;
    localparam int B_W   = 18;
    localparam int Z_W   = A_W + B_W;
    localparam int CNT_W = 16;

    typedef logic [Z_W-1:0] dsp_prod_t;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic           unsigned_a;
        logic           unsigned_b;
`ifdef DSP_MULT_RESP_ACC_EN
        logic           acc_clr;
`endif
    } dsp_req_t;

    // Extend the low w bits of v to Z_W: zero-fill when uns, else replicate bit w-1
    function automatic dsp_prod_t sext_op(input logic [A_W-1:0] v, input int w, input logic uns);
        dsp_prod_t m;
        logic      s;
        m = (dsp_prod_t'(1) << w) - dsp_prod_t'(1);
        s = !uns && |(dsp_prod_t'(v) & (dsp_prod_t'(1) << (w - 1)));
        return s ? (dsp_prod_t'(v) | ~m) : (dsp_prod_t'(v) & m);
    endfunction
endpackage

// File: rtl/dsp_mult_resp_stage.sv
// dsp_mult_resp_stage: enable-gated valid + payload pipeline register
module dsp_mult_resp_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    // Capture valid and payload together whenever the stage is enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/dsp_mult_resp.sv
// dsp_mult_resp: two-stage 20x18 multiply responder with valid/ready on both sides
// Optional accumulator mode selected by DSP_MULT_RESP_ACC_EN.
module dsp_mult_resp
    import dsp_mult_resp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             unsigned_a,
    input  logic             unsigned_b,
`ifdef DSP_MULT_RESP_ACC_EN
    input  logic             acc_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Z_W-1:0]   z,
    output logic [CNT_W-1:0] resp_count
);
    logic             w_adv;
    logic             w_s1_valid;
    dsp_req_t         w_req;
    dsp_req_t         w_s1_req;
    dsp_prod_t        w_prod;
    dsp_prod_t        w_s2_in;
    logic [CNT_W-1:0] r_cnt;

    // Whole pipeline advances when the output slot is free or being drained;
    // an empty S1 may still fill while S2 is stalled
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv || !w_s1_valid;

    // Pack the request beat
    always_comb begin
        w_req            = '0;
        w_req.a          = a;
        w_req.b          = b;
        w_req.unsigned_a = unsigned_a;
        w_req.unsigned_b = unsigned_b;
`ifdef DSP_MULT_RESP_ACC_EN
        w_req.acc_clr    = acc_clr;
`endif
    end

    dsp_mult_resp_stage #(.W($bits(dsp_req_t))) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .i_en    (in_ready),
        .i_valid (in_valid),
        .i_data  (w_req),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_req)
    );

    assign w_prod = sext_op(w_s1_req.a, A_W, w_s1_req.unsigned_a)
                  * sext_op({{(A_W-B_W){1'b0}}, w_s1_req.b}, B_W, w_s1_req.unsigned_b);

`ifdef DSP_MULT_RESP_ACC_EN
    dsp_prod_t r_acc;

    assign w_s2_in = (w_s1_req.acc_clr ? '0 : r_acc) + w_prod;

    // Accumulate only when a real beat moves into S2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_acc <= '0;
        else if (w_adv && w_s1_valid) r_acc <= w_s2_in;
    end
`else
    assign w_s2_in = w_prod;
`endif

    dsp_mult_resp_stage #(.W(Z_W)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_adv),
        .i_valid (w_s1_valid),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .o_data  (z)
    );

    // Count completed responses, sticking at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else if (out_valid && out_ready && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign resp_count = r_cnt;
endmodule
